dac_i2s_serializer: RTL and testbench
=====================================

# dac_i2s_serializer

Output stage of the ANC datapath: accepts one-cycle `sample_vld` pulses carrying the 16-bit anti-noise/audio sample from the ANC core and serializes it to the external DAC as a Philips-format I2S stream. The same mono sample is sent in both the left and right slots. It generates its own bit clock from the system clock using the runtime-programmed output clock period. A 2-entry sample FIFO absorbs jitter between the ANC output rate and the DAC frame rate. Sticky flags report overflow and underrun.

## Interface
- `SAMPLE_W`, default 16: sample width in bits.
- `SLOT_W`, default 32: bit-clock cycles per channel slot; must be ≥ `SAMPLE_W`+1.
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `bclk_period`, input, 8: bit-clock half-period in `clk` cycles; 0 freezes the serializer.
- `sample_vld`, input, 1: one-cycle push strobe.
- `sample`, input, `SAMPLE_W`: signed sample, valid with `sample_vld`.
- `bclk`, output, 1: I2S bit clock (registered).
- `lr_clk`, output, 1: I2S word select; 0 = left, 1 = right (registered).
- `dout`, output, 1: I2S serial data, MSB first (registered).
- `fifo_level`, output, 2: current FIFO occupancy, 0..2.
- `overflow`, output, 1: sticky; set when a push is dropped. Cleared only by reset.
- `underrun`, output, 1: sticky; set when a frame starts with the FIFO empty. Cleared only by reset.

## Operation
- **Divider**
  - `div_cnt` increments each `clk` while `bclk_period` ≠ 0.
  - When `div_cnt` ≥ `bclk_period`−1: `div_cnt` ← 0 and `bclk` toggles.
  - The `≥` compare makes a mid-run decrease of `bclk_period` safe.
  - When `bclk_period` = 0: `div_cnt`, `bclk` and all frame state hold their values.
- **Falling-edge event**
  - Fires in the cycle where the divider toggles `bclk` from 1 to 0.
  - All frame state advances only on this event.
- **Frame position `pos`** (0..2·`SLOT_W`−1)
  - Wraps from 2·`SLOT_W`−1 to 0.
  - On each falling-edge event: `lr_clk` ← 0 if the new `pos` < `SLOT_W`, else 1.
- **`dout` for the new `pos`**
  - `pos` in 1..`SAMPLE_W`: `shreg[SAMPLE_W-pos]`.
  - `pos` in `SLOT_W`+1..`SLOT_W`+`SAMPLE_W`: `shreg[SAMPLE_W-(pos-SLOT_W)]`.
  - Otherwise: 0.
- **Frame load** (falling-edge event with new `pos` = 0)
  - FIFO non-empty: pop the head into `shreg`.
  - FIFO empty: `shreg` keeps its previous sample and `underrun` ← 1.
- **FIFO**: 2 entries, first in first out.
  - Push with FIFO not full: accepted.
  - Push with FIFO full and no pop in the same cycle: sample dropped and `overflow` ← 1.
  - Push and pop in the same cycle with FIFO full: both occur; level stays 2; no overflow.
  - Push and pop in the same cycle with FIFO empty: the frame-load underrun rule applies; the pushed sample is stored; level becomes 1. There is no bypass path.
- **Width rules**: none. The sample is transmitted unmodified in two's complement, zero-padded to `SLOT_W`.

## Timing
- **Reset values**
  - `bclk`=0, `lr_clk`=1, `dout`=0, `pos`=2·`SLOT_W`−1, `div_cnt`=0.
  - `shreg`=0, `fifo_level`=0, `overflow`=0, `underrun`=0.
- **Bit clock**: period 2·`bclk_period` `clk` cycles; one frame is 2·`SLOT_W` bit clocks.
- **First falling edge after reset**: `pos` becomes 0, a frame load occurs, and `lr_clk` goes 0.
- **Left-slot MSB**: appears on `dout` at the falling edge with `pos`=1, i.e. one bit clock after the `lr_clk` transition (standard I2S). All changes on `lr_clk`/`dout` coincide with `bclk` falling.
- **Push latency**: a push is counted in `fifo_level` in the cycle after `sample_vld`. It is transmitted in the next frame whose load occurs at least 1 cycle after the push.
- **Reset mid-frame**: all outputs return to reset values immediately (asynchronous). The partial frame is abandoned and the FIFO contents are discarded.
- **`bclk_period` change**: takes effect at the next divider compare. Frame position is preserved.

## Test plan
- **Basic frame**: reset, `bclk_period`=2, push 0xA5C3 before the first falling edge.
  - `bclk` period is 4 clk; a frame is 256 clk.
  - `lr_clk` is 0 for 128 clk, then 1 for 128 clk.
  - `dout` bits at `pos` 1..16 read 1010010111000011; the same pattern appears at `pos` 33..48; all other positions are 0.
- **Underrun repeat**: after 0xA5C3 is sent, push nothing.
  - The second frame retransmits 0xA5C3.
  - `underrun` rises at that frame's `pos`=0 event and stays 1.
- **Overflow**: with a load pending, push 0x1111, 0x2222, 0x3333 in consecutive cycles, with no pop among them.
  - `fifo_level` reads 2 and `overflow`=1.
  - The next frames carry 0x1111, then 0x2222.
- **Full push + pop**: with FIFO full, assert `sample_vld` in the exact cycle of a frame load.
  - `overflow` stays 0 and `fifo_level` stays 2.
  - The FIFO order is preserved.
- **Divider corner cases**:
  - `bclk_period`=1 gives `bclk` period 2 clk.
  - Dropping `bclk_period` from 8 to 3 mid-count toggles `bclk` on the next cycle, with no lockup.
  - `bclk_period`=0 freezes `bclk`, `lr_clk`, `dout` and `pos`; they resume from the same `pos` when the period is restored.
- **Reset mid-frame**: assert `rst_n`=0 at `pos`=20.
  - All outputs reach reset values within the same cycle.
  - After release, the first frame starts at `pos`=0 with `underrun` set, since the FIFO is empty.

Source files
------------

// File: rtl/dac_i2s_serializer.sv
// I2S output stage: buffers mono samples in a 2-entry FIFO and sends each one
// in both slots of a Philips-format frame, with a bit clock divided from clk.
module dac_i2s_serializer #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned SLOT_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          bclk_period,
    input  logic                sample_vld,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                bclk,
    output logic                lr_clk,
    output logic                dout,
    output logic [1:0]          fifo_level,
    output logic                overflow,
    output logic                underrun
);

    localparam int unsigned FRAME_LEN = 2 * SLOT_W;
    localparam int unsigned POS_W     = $clog2(FRAME_LEN);
    localparam int unsigned BIT_W     = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    // Divider and frame state
    logic [7:0]          div_cnt_q;
    logic                bclk_q;
    logic                lr_q;
    logic                dout_q;
    logic [POS_W-1:0]    pos_q;
    logic [SAMPLE_W-1:0] shreg_q;

    // Sample FIFO
    logic [SAMPLE_W-1:0] mem_q [2];
    logic                rd_ptr_q;
    logic                wr_ptr_q;
    logic [1:0]          level_q;
    logic [1:0]          level_d;
    logic                overflow_q;
    logic                underrun_q;

    // Event decode
    logic                div_run;
    logic                div_wrap;
    logic                fall_evt;
    logic [POS_W-1:0]    pos_nxt;
    logic                load;
    logic                pop;
    logic                push_ok;
    logic                drop;

    // Next bit on the serial line
    logic [31:0]         pos_ext;
    logic [BIT_W-1:0]    bit_sel;
    logic                lr_nxt;
    logic                dout_nxt;

    // >= rather than == so that lowering bclk_period below div_cnt wraps at once
    assign div_run  = (bclk_period != 8'd0);
    assign div_wrap = div_run && (div_cnt_q >= (bclk_period - 8'd1));
    assign fall_evt = div_wrap && bclk_q;
    assign pos_nxt  = (pos_q == POS_LAST) ? '0 : (pos_q + POS_ONE);
    assign load     = fall_evt && (pos_nxt == '0);

    // A load pops only a non-empty FIFO; a push into a full FIFO needs that pop to fit
    assign pop      = load && (level_q != 2'd0);
    assign push_ok  = sample_vld && ((level_q != 2'd2) || pop);
    assign drop     = sample_vld && !push_ok;

    // Select lr_clk and the data bit that go out at the new frame position
    always_comb begin
        pos_ext  = 32'(pos_nxt);
        lr_nxt   = (pos_ext >= SLOT_W);
        dout_nxt = 1'b0;
        bit_sel  = '0;
        if ((pos_ext >= 32'd1) && (pos_ext <= SAMPLE_W)) begin
            bit_sel  = BIT_W'(SAMPLE_W - pos_ext);
            dout_nxt = shreg_q[bit_sel];
        end else if ((pos_ext >= SLOT_W + 1) && (pos_ext <= SLOT_W + SAMPLE_W)) begin
            bit_sel  = BIT_W'(SLOT_W + SAMPLE_W - pos_ext);
            dout_nxt = shreg_q[bit_sel];
        end
    end

    // FIFO occupancy after this cycle's push and pop
    always_comb begin
        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + 2'd1;
        end else if (pop && !push_ok) begin
            level_d = level_q - 2'd1;
        end
    end

    // Bit-clock divider; holds completely while bclk_period is zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= 8'd0;
            bclk_q    <= 1'b0;
        end else if (div_run) begin
            if (div_wrap) begin
                div_cnt_q <= 8'd0;
                bclk_q    <= ~bclk_q;
            end else begin
                div_cnt_q <= div_cnt_q + 8'd1;
            end
        end
    end

    // Frame position, word select, data and frame load, all on bclk falling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= POS_LAST;
            lr_q       <= 1'b1;
            dout_q     <= 1'b0;
            shreg_q    <= '0;
            underrun_q <= 1'b0;
        end else if (fall_evt) begin
            pos_q  <= pos_nxt;
            lr_q   <= lr_nxt;
            dout_q <= dout_nxt;
            if (load) begin
                if (pop) begin
                    shreg_q <= mem_q[rd_ptr_q];
                end else begin
                    underrun_q <= 1'b1;
                end
            end
        end
    end

    // Two-entry FIFO storage, pointers, level and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            level_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push_ok) begin
                mem_q[wr_ptr_q] <= sample;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            level_q <= level_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bclk       = bclk_q;
    assign lr_clk     = lr_q;
    assign dout       = dout_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_i2s_serializer.sv
// Bench for dac_i2s_serializer: a queue-based model predicts which sample each
// frame carries; a monitor decodes the I2S stream and checks it against that.
module tb_dac_i2s_serializer;

    localparam int SW = 16;
    localparam int SL = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    bclk_period = 8'd0;
    logic          sample_vld = 1'b0;
    logic [SW-1:0] sample = '0;
    logic          bclk;
    logic          lr_clk;
    logic          dout;
    logic [1:0]    fifo_level;
    logic          overflow;
    logic          underrun;

    dac_i2s_serializer #(
        .SAMPLE_W (SW),
        .SLOT_W   (SL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bclk_period (bclk_period),
        .sample_vld  (sample_vld),
        .sample      (sample),
        .bclk        (bclk),
        .lr_clk      (lr_clk),
        .dout        (dout),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t = 0;          // clk edges since reset release, as seen by the driver
    bit model_en = 1'b0;

    // Reference model state
    int            ecnt;
    logic [SW-1:0] mq[$];   // model FIFO contents
    logic [SW-1:0] sb[$];   // expected sample of each started frame
    logic [SW-1:0] cur;
    bit            m_over;
    bit            m_under;
    int            mp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0d", name, act, exp, t);
        end
    endtask

    // Frame position after edge e at constant period p (falls every 2p edges)
    function automatic int pos_at(input int e, input int p);
        int m;
        m = e / (2 * p);
        if (m == 0) return 2 * SL - 1;
        return (m - 1) % (2 * SL);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset(input int p, input bit en);
        rst_n       = 1'b0;
        model_en    = en;
        bclk_period = 8'(p);
        sample_vld  = 1'b0;
        #1;
        repeat (3) step();
        rst_n = 1'b1;
        t     = 0;
    endtask

    // Drive a push so that the DUT sees it at edge e
    task automatic push_at(input int e, input logic [SW-1:0] v);
        while (t < e - 1) step();
        sample     = v;
        sample_vld = 1'b1;
        step();
        sample_vld = 1'b0;
    endtask

    // Model: frame loads every 2*SL bit clocks starting at the first falling edge
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                ecnt    = 0;
                mq.delete();
                sb.delete();
                cur     = '0;
                m_over  = 1'b0;
                m_under = 1'b0;
            end else if (model_en) begin
                mp = int'(bclk_period);
                ecnt++;
                if ((ecnt % (4 * SL * mp)) == 2 * mp) begin
                    if (mq.size() > 0) cur = mq.pop_front();
                    else m_under = 1'b1;
                    sb.push_back(cur);
                end
                if (sample_vld) begin
                    if (mq.size() < 2) mq.push_back(sample);
                    else m_over = 1'b1;
                end
            end
        end
    end

    // Monitor: decode the serial stream and score each completed frame
    logic          prev_bclk, prev_lr, prev_dout, fall;
    bit            in_frame, have_t0, bad;
    int            bitidx, cyc, t0;
    logic [SW-1:0] left, right, expv;

    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n || !model_en) begin
                in_frame = 1'b0;
                have_t0  = 1'b0;
            end else begin
                check("fifo_level", 32'(fifo_level), 32'(mq.size()));
                check("overflow", 32'(overflow), 32'(m_over));
                check("underrun", 32'(underrun), 32'(m_under));
                fall = prev_bclk && !bclk;
                if ((lr_clk !== prev_lr) || (dout !== prev_dout))
                    check("edge_align", 32'(fall), 32'd1);
                if (fall) begin
                    if (prev_lr && !lr_clk) begin
                        if (have_t0)
                            check("frame_len", 32'(cyc - t0), 32'(4 * SL * int'(bclk_period)));
                        t0       = cyc;
                        have_t0  = 1'b1;
                        in_frame = 1'b1;
                        bitidx   = 0;
                        left     = '0;
                        right    = '0;
                        bad      = 1'b0;
                    end else if (in_frame) begin
                        bitidx++;
                    end
                    if (in_frame) begin
                        if (lr_clk !== (bitidx >= SL)) bad = 1'b1;
                        if (bitidx >= 1 && bitidx <= SW) left = {left[SW-2:0], dout};
                        else if (bitidx >= SL + 1 && bitidx <= SL + SW)
                            right = {right[SW-2:0], dout};
                        else if (dout !== 1'b0) bad = 1'b1;
                        if (bitidx == 2 * SL - 1) begin
                            if (sb.size() == 0) begin
                                check("sb_nonempty", 32'd0, 32'd1);
                            end else begin
                                expv = sb.pop_front();
                                check("left_slot", 32'(left), 32'(expv));
                                check("right_slot", 32'(right), 32'(expv));
                                check("frame_format", 32'(bad), 32'd0);
                            end
                            in_frame = 1'b0;
                        end
                    end
                end
            end
            prev_bclk = bclk;
            prev_lr   = lr_clk;
            prev_dout = dout;
        end
    end

    int   cnt, mism;
    logic pb, b14, fz_bclk, fz_lr, fz_dout;

    initial begin
        // Basic frame, underrun repeat, full push+pop, overflow (period 2: loads at 4+256k)
        do_reset(2, 1'b1);
        check("rst_bclk", 32'(bclk), 32'd0);
        check("rst_lr", 32'(lr_clk), 32'd1);
        push_at(1, 16'hA5C3);
        while (t < 259) step();
        check("underrun_before", 32'(underrun), 32'd0);
        step();
        check("underrun_at_load", 32'(underrun), 32'd1);
        push_at(300, 16'h1111);
        push_at(301, 16'h2222);
        check("full_level", 32'(fifo_level), 32'd2);
        push_at(516, 16'h3333);
        check("pushpop_level", 32'(fifo_level), 32'd2);
        check("pushpop_no_ovf", 32'(overflow), 32'd0);
        push_at(1300, 16'h1111);
        push_at(1301, 16'h2222);
        push_at(1302, 16'h3333);
        check("ovf_level", 32'(fifo_level), 32'd2);
        check("ovf_flag", 32'(overflow), 32'd1);

        // Reset at pos 20 of frame 8
        while (t < 4 * (64 * 8 + 21)) step();
        check("pos20_lr", 32'(lr_clk), 32'(pos_at(t, 2) >= SL));
        rst_n = 1'b0;
        #1;
        check("arst_bclk", 32'(bclk), 32'd0);
        check("arst_lr", 32'(lr_clk), 32'd1);
        check("arst_dout", 32'(dout), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_und", 32'(underrun), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        t     = 0;
        while (t < 4) step();
        check("underrun_after_rst", 32'(underrun), 32'd1);

        // Random pushes against the model
        while (t < 2600) begin
            if ($urandom_range(0, 199) == 0) begin
                sample     = 16'($urandom);
                sample_vld = 1'b1;
            end
            step();
            sample_vld = 1'b0;
        end

        // Period 1 gives a 2-cycle bit clock
        do_reset(1, 1'b0);
        while (t < 5) step();
        cnt = 0;
        pb  = bclk;
        repeat (10) begin
            step();
            if (bclk !== pb) cnt++;
            pb = bclk;
        end
        check("p1_toggles", 32'(cnt), 32'd10);

        // Lowering 8 -> 3 with div_cnt at 6 wraps on the next edge
        do_reset(8, 1'b0);
        while (t < 14) step();
        b14         = bclk;
        bclk_period = 8'd3;
        step();
        check("drop_toggle", 32'(bclk !== b14), 32'd1);
        cnt = 0;
        pb  = bclk;
        repeat (12) begin
            step();
            if (bclk !== pb) cnt++;
            pb = bclk;
        end
        check("p3_toggles", 32'(cnt), 32'd4);

        // Freeze with period 0 for 40 edges, then resume from the same position
        do_reset(2, 1'b0);
        mism = 0;
        while (t < 300) begin
            step();
            if (int'(bclk) != (t / 2) % 2) mism++;
            if (int'(lr_clk) != int'(pos_at(t, 2) >= SL)) mism++;
        end
        check("run_before_freeze", 32'(mism), 32'd0);
        bclk_period = 8'd0;
        fz_bclk     = bclk;
        fz_lr       = lr_clk;
        fz_dout     = dout;
        mism        = 0;
        while (t < 340) begin
            step();
            if ((bclk !== fz_bclk) || (lr_clk !== fz_lr) || (dout !== fz_dout)) mism++;
        end
        check("frozen", 32'(mism), 32'd0);
        bclk_period = 8'd2;
        mism        = 0;
        while (t < 700) begin
            step();
            if (int'(bclk) != ((t - 40) / 2) % 2) mism++;
            if (int'(lr_clk) != int'(pos_at(t - 40, 2) >= SL)) mism++;
        end
        check("resume_after_freeze", 32'(mism), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
